// File: rtl/blit_memif.sv
// Blitter memory-cycle front end: bus grant handshake plus conversion of each
// blitter cycle into one registered 64-bit phrase-port transaction.
module blit_memif #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [1:0]  blit_breq,
    input  logic        bus_busy,
    output logic        blit_back,
    input  logic        mreq,
    input  logic        read,
    input  logic [3:0]  width,
    input  logic        justify,
    input  logic [23:0] blit_addr,
    input  logic [63:0] wdata,
    output logic        ack,
    output logic [63:0] data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OWN   = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [2:0]  r_state;
    logic        r_rst_hold;
    logic        r_back;
    logic        r_err;
    logic [63:0] r_data;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [20:0] r_mem_addr;
    logic [7:0]  r_mem_be;
    logic [63:0] r_mem_wdata;
    logic        r_read;
    logic        r_just;
    logic [2:0]  r_off;
    logic [7:0]  r_wd;

    logic [3:0]  w_width;
    logic [15:0] w_mask;
    logic [7:0]  w_be;
    logic [63:0] w_rdata_j;
    logic [7:0]  w_wd_next;
    logic        w_grant;

    always_comb begin
        w_width   = ((width == 4'd0) || (width > 4'd8)) ? 4'd8 : width;
        // Mask is built 16 bits wide so lanes pushed past byte 7 simply fall off.
        w_mask    = ((16'd1 << w_width) - 16'd1) << blit_addr[2:0];
        w_be      = w_mask[7:0];
        w_rdata_j = r_just ? (mem_rdata >> {r_off, 3'b000}) : mem_rdata;
        w_wd_next = r_wd + 8'd1;
        w_grant   = !r_rst_hold && blit_breq[0] && (!bus_busy || blit_breq[1]);
    end

    always_ff @(posedge clk or posedge xreset) begin
        if (xreset) begin
            r_state     <= S_IDLE;
            r_rst_hold  <= 1'b1;
            r_back      <= 1'b0;
            r_err       <= 1'b0;
            r_data      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_read      <= 1'b0;
            r_just      <= 1'b0;
            r_off       <= '0;
            r_wd        <= '0;
        end else begin
            // Grant is held off for one edge after reset release.
            r_rst_hold <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_OWN;
                        r_back  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_OWN: begin
                    if (mreq) begin
                        r_read      <= read;
                        r_just      <= justify;
                        r_off       <= blit_addr[2:0];
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ~read;
                        r_mem_addr  <= blit_addr[23:3];
                        r_mem_be    <= w_be;
                        r_mem_wdata <= wdata;
                        r_state     <= S_REQ;
                    end else if (!blit_breq[0]) begin
                        r_back  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_rdy) begin
                        r_mem_req <= 1'b0;
                        if (r_read) begin
                            r_wd    <= '0;
                            r_state <= S_RWAIT;
                        end else begin
                            r_state <= S_ACK;
                        end
                    end
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        r_data  <= w_rdata_j;
                        r_state <= S_ACK;
                    end else begin
                        r_wd <= w_wd_next;
                        if (w_wd_next == TMO) begin
                            r_err   <= 1'b1;
                            r_data  <= '0;
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_OWN;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign blit_back = r_back;
    assign ack       = (r_state == S_ACK);
    assign data      = r_data;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: doc/blit_memif.md
# blit_memif

Memory-cycle front end directly downstream of the blitter. It arbitrates the blitter's bus request against other masters and issues a grant back to the blitter. It converts each blitter memory cycle (address, width, read/write, write data, justify) into a single-beat transaction on a 64-bit phrase memory port, then returns ack and read data to the blitter.

## Interface
Parameters:
- TIMEOUT, 255, read-wait watchdog limit in cycles (1..255); counter is 8 bits.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- xreset  in  1  asynchronous, active-high reset.
- blit_breq  in  2  bit0 = blitter wants bus, bit1 = high priority (overrides bus_busy).
- bus_busy  in  1  another master currently owns memory.
- blit_back  out  1  bus grant acknowledge to blitter.
- mreq  in  1  blitter memory-cycle strobe; valid only while blit_back=1.
- read  in  1  1 = read cycle, 0 = write.
- width  in  4  transfer size in bytes, 1..8; 0 or >8 means 8.
- justify  in  1  read data returned right-justified to byte 0.
- blit_addr  in  24  byte address.
- wdata  in  64  write data, already in phrase byte lanes.
- ack  out  1  one-cycle completion pulse.
- data  out  64  read data to blitter.
- err  out  1  sticky watchdog-timeout flag.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  write enable for the current request.
- mem_addr  out  21  phrase address = blit_addr[23:3].
- mem_be  out  8  byte enables, bit i = byte lane i.
- mem_wdata  out  64  write data.
- mem_rdy  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid on mem_rdata.
- mem_rdata  in  64  read data.

## Operation
- States: IDLE, OWN, REQ, RWAIT, ACK.
- IDLE: when blit_breq[0]=1 and (bus_busy=0 or blit_breq[1]=1), move to OWN, set blit_back=1, clear err.
- OWN:
  - If mreq=1, latch blit_addr, width, read, justify and wdata into command registers, then go to REQ.
  - Else if blit_breq[0]=0, go to IDLE and clear blit_back.
  - mreq takes precedence over release.
- REQ:
  - mem_req=1; mem_we=~read; mem_addr, mem_be and mem_wdata come from the latched command.
  - On mem_rdy=1: a write goes to ACK; a read goes to RWAIT with the watchdog cleared.
- RWAIT:
  - On mem_rvalid=1, capture data and go to ACK.
  - Otherwise increment the watchdog. When it reaches TIMEOUT, set err=1, load data=0 and go to ACK.
- ACK: ack=1 for exactly one cycle, then go to OWN.
- blit_back stays 1 from OWN entry until IDLE re-entry, including during REQ, RWAIT and ACK.
- If breq drops mid-cycle, the cycle still completes and release happens in the following OWN.
- Byte enables: n = effective width, o = addr[2:0]; mem_be = (((1<<n)-1) << o) & 8'hFF. Lanes past byte 7 are dropped, with no second beat.
- Read data:
  - justify=0: data = mem_rdata.
  - justify=1: data = mem_rdata >> (8*o), zero-filled in the upper bytes.
- data holds its value until the next read capture. Write cycles leave data unchanged.
- err stays 1 until the next grant (IDLE->OWN).

## Timing
- Reset values: state IDLE; blit_back=0, ack=0, data=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, watchdog=0.
- Grant latency: breq sampled in IDLE -> blit_back=1 on the next cycle.
- Write with mem_rdy tied high: mreq sampled in OWN at cycle t, mem_req high at t+1, ack at t+2, next mreq sampled at t+3. Minimum is 3 cycles per cycle.
- Read: ack comes one cycle after the mem_rvalid sample. With rdy=1 and rvalid the cycle after acceptance, the total is 4 cycles.
- mem_req/addr/be/we/wdata are registered and stay stable while mem_req=1 and mem_rdy=0.
- mem_rvalid is ignored outside RWAIT.
- Asynchronous xreset mid-operation:
  - All outputs return to their reset values immediately and any in-flight memory request is abandoned.
  - The first grant is possible on the second clock edge after deassertion.

## Test plan
- Grant/release: breq=01, bus_busy=0 -> blit_back=1 next cycle. Drop breq -> blit_back=0 one cycle later. With bus_busy=1 and breq=01 there is no grant; with breq=11 the grant is given.
- Write: addr=24'h000105, width=2, wdata=64'h0000_FFFF_0000_0000, rdy=1 -> mem_be=8'h60, mem_addr=21'h000020, mem_we=1, ack 2 cycles after the mreq sample.
- Justified read: addr=24'h000203, width=2, justify=1, mem_rdata=64'h1122334455667788 -> mem_be=8'h18, data=64'h0000001122334455, ack one cycle after rvalid.
- Backpressure: mem_rdy low for 5 cycles -> mem_req and address held stable 6 cycles; ack only after acceptance. A simultaneous breq drop during this finishes the cycle before release.
- Watchdog: read accepted, rvalid never asserted -> err=1, data=0, ack at TIMEOUT+1 cycles after acceptance. err is cleared on the next grant.
- Reset: assert xreset during RWAIT -> all outputs 0 at once. A new grant then completes a width=0 write with mem_be=8'hFF.
